// File: rtl/display_update_sequencer.sv
// rtl/display_update_sequencer.sv - shadow frame buffer with dirty tracking that drives writepixels update bursts
// Each burst issues the control command, waits out the settle pause, then writes only the dirty bytes.
module display_update_sequencer #(
    parameter int         CLK_HZ       = 25_000_000,
    parameter int         PAUSE_CYCLES = CLK_HZ / 1000,
    parameter logic [7:0] CMD_BASE     = 8'h88,
    parameter logic [7:0] ADDR_BASE    = 8'hC0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_refresh,
    input  logic [2:0] i_brightness,
    input  logic       i_busy,
    output logic       o_valid,
    output logic [7:0] o_pos,
    output logic [7:0] o_value,
    output logic       o_idle
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_SCAN  = 3'd3;
    localparam logic [2:0] ST_SEND  = 3'd4;
    localparam logic [2:0] ST_GUARD = 3'd5;

    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             guard_q, guard_d;
    logic             gcmd_q, gcmd_d;
    logic [15:0]      dirty_q, dirty_d;
    logic             valid_q, valid_d;
    logic [7:0]       pos_q, pos_d;
    logic [7:0]       value_q, value_d;
    logic [7:0]       shadow_q [16];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= 8'h00;
        end else if (i_wr_en) begin
            shadow_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        guard_d = guard_q;
        gcmd_d  = gcmd_q;
        dirty_d = dirty_q;
        valid_d = 1'b0;
        pos_d   = pos_q;
        value_d = value_q;
        case (state_q)
            ST_IDLE: begin
                if (|dirty_q) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (!i_busy) begin
                    valid_d = 1'b1;
                    pos_d   = 8'h00;
                    value_d = CMD_BASE | {5'b00000, i_brightness};
                    cnt_d   = '0;
                    guard_d = 1'b0;
                    gcmd_d  = 1'b1;
                    state_d = ST_GUARD;
                end
            end
            ST_PAUSE: begin
                if (cnt_q == PAUSE_LAST) begin
                    idx_d   = 4'd0;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SCAN: begin
                if (dirty_q[idx_q]) begin
                    state_d = ST_SEND;
                end else if (idx_q == 4'd15) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_SEND: begin
                if (!i_busy) begin
                    valid_d        = 1'b1;
                    pos_d          = ADDR_BASE + {4'b0000, idx_q};
                    value_d        = shadow_q[idx_q];
                    dirty_d[idx_q] = 1'b0;
                    guard_d        = 1'b0;
                    gcmd_d         = 1'b0;
                    state_d        = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // First guard cycle gives the driver time to raise busy before we sample it
                if (!guard_q) begin
                    guard_d = 1'b1;
                end else if (!i_busy) begin
                    if (gcmd_q) begin
                        state_d = ST_PAUSE;
                    end else if (idx_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Setting a dirty bit overrides the clear from SEND in the same cycle
        if (i_refresh) dirty_d = 16'hFFFF;
        if (i_wr_en) dirty_d[i_wr_addr] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            guard_q <= 1'b0;
            gcmd_q  <= 1'b0;
            dirty_q <= 16'hFFFF;
            valid_q <= 1'b0;
            pos_q   <= 8'h00;
            value_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
            gcmd_q  <= gcmd_d;
            dirty_q <= dirty_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            value_q <= value_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pos   = pos_q;
    assign o_value = value_q;
    assign o_idle  = (state_q == ST_IDLE) && !(|dirty_q);

endmodule

// File: tb/tb_display_update_sequencer.sv
// tb/tb_display_update_sequencer.sv - scoreboard bench for display_update_sequencer
// Expected transfers are queued by the stimulus; the monitor pops and compares on each o_valid pulse.
module tb_display_update_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       refresh = 1'b0;
    logic [2:0] brightness = 3'd1;
    logic       busy;
    logic       force_busy = 1'b0;
    logic       o_valid;
    logic [7:0] o_pos;
    logic [7:0] o_value;
    logic       o_idle;

    int         busy_cnt = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_pulse = 0;
    bit         prev_v = 1'b0;
    logic [15:0] exp_q [$];
    logic [7:0]  model_sh [16];

    always #5 clk = ~clk;

    display_update_sequencer #(
        .CLK_HZ(25_000_000),
        .PAUSE_CYCLES(4),
        .CMD_BASE(8'h88),
        .ADDR_BASE(8'hC0)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_refresh(refresh),
        .i_brightness(brightness),
        .i_busy(busy),
        .o_valid(o_valid),
        .o_pos(o_pos),
        .o_value(o_value),
        .o_idle(o_idle)
    );

    // Driver model: busy for 10 cycles after each accepted transfer
    always @(posedge clk) begin
        if (o_valid) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy = force_busy | (busy_cnt != 0);

    always @(negedge clk) begin
        if (o_valid) begin
            logic [15:0] e;
            n_pulse++;
            n_cmp++;
            if (prev_v || busy) begin
                n_fail++;
                $display("FAIL protocol pulse #%0d: prev_valid=%0b busy=%0b, required 0/0", n_pulse, prev_v, busy);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected pulse #%0d: pos/value %h/%h, required no pulse", n_pulse, o_pos, o_value);
            end else begin
                e = exp_q.pop_front();
                if ({o_pos, o_value} !== e) begin
                    n_fail++;
                    $display("FAIL pulse #%0d: pos/value %h/%h, required %h/%h", n_pulse, o_pos, o_value, e[15:8], e[7:0]);
                end
            end
        end
        prev_v = o_valid;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [7:0] v);
        exp_q.push_back({p, v});
    endtask

    task automatic push_full(input logic [2:0] b);
        push(8'h00, 8'h88 | {5'b00000, b});
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i), model_sh[i]);
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_sh[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (o_idle && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: idle not reached, pending=%0d idle=%0b, required 0/1", name, exp_q.size(), o_idle);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input logic [3:0] ix, input bit need_valid);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (dut.state_q == st && dut.idx_q == ix && (!need_valid || o_valid)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: state not reached, found=0, required 1", name);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_sh[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {7'd0, o_valid}, 8'h00);
        check("reset_pos", o_pos, 8'h00);
        check("reset_value", o_value, 8'h00);
        check("reset_idle", {7'd0, o_idle}, 8'h00);

        // Full burst out of reset
        push_full(3'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle("reset_burst");

        // Single dirty byte
        push(8'h00, 8'h89);
        push(8'hC5, 8'hA5);
        write(4'd5, 8'hA5);
        wait_idle("single_write");

        // Driver busy held while the command waits
        brightness = 3'd6;
        force_busy = 1'b1;
        push(8'h00, 8'h8E);
        push(8'hCA, 8'h5A);
        write(4'd10, 8'h5A);
        repeat (50) @(posedge clk);
        #1;
        force_busy = 1'b0;
        @(negedge clk);
        check("busy_fall_cycle_valid", {7'd0, o_valid}, 8'h00);
        @(negedge clk);
        check("first_cycle_after_busy_valid", {7'd0, o_valid}, 8'h01);
        @(posedge clk); #1;
        brightness = 3'd1;
        wait_idle("busy_hold");

        // Refresh rewrites the whole frame
        push_full(3'd1);
        pulse_refresh();
        wait_idle("refresh");

        // Write collides with SEND of the same index
        brightness = 3'd2;
        push_full(3'd2);
        pulse_refresh();
        wait_state("send_idx3", 3'd4, 4'd3, 1'b0);
        write(4'd3, 8'h3C);
        push(8'h00, 8'h8A);
        push(8'hC3, 8'h3C);
        wait_idle("send_collision");

        // Reset in the guard after byte 7
        push_full(3'd2);
        pulse_refresh();
        wait_state("guard_idx7", 3'd5, 4'd7, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_valid", {7'd0, o_valid}, 8'h00);
        check("midreset_pos", o_pos, 8'h00);
        check("midreset_value", o_value, 8'h00);
        check("midreset_idle", {7'd0, o_idle}, 8'h00);
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_sh[i] = 8'h00;
        push_full(3'd2);
        wait_idle("post_reset_burst");

        repeat (30) @(negedge clk);
        check("final_idle", {7'd0, o_idle}, 8'h01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_update_sequencer.md
# display_update_sequencer

Sequencer that sits between user logic and the `writepixels` serial LED/segment driver. It holds a 16-byte shadow frame buffer with per-byte dirty flags. When any byte is dirty it runs an update burst: display-control command, settle pause, then each dirty byte written to its display address. It owns the driver's `valid`/`pos`/`value` inputs and obeys its `busy` output, replacing hand-coded fixed write sequences in top-level designs.

## Interface
- `CLK_HZ`, 25_000_000: input clock rate.
- `PAUSE_CYCLES`, CLK_HZ/1000: settle cycles after the control command (1 ms).
- `CMD_BASE`, 8'h88: control command base; the issued command is `CMD_BASE | {5'b0, brightness}`.
- `ADDR_BASE`, 8'hC0: display address of byte 0; byte n is issued at `ADDR_BASE + n`.
- `CLK`  in  1  system clock, all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `i_wr_en`  in  1  write strobe for the shadow buffer.
- `i_wr_addr`  in  4  shadow byte index 0..15.
- `i_wr_data`  in  8  segment pattern to store.
- `i_refresh`  in  1  one-cycle pulse: mark all 16 bytes dirty.
- `i_brightness`  in  3  brightness field, sampled when the command is issued.
- `i_busy`  in  1  driver busy flag.
- `o_valid`  out  1  one-cycle transfer strobe to the driver.
- `o_pos`  out  8  driver address/command-type byte.
- `o_value`  out  8  driver data byte.
- `o_idle`  out  1  high in IDLE with no dirty bytes.

## Operation
- Reset values:
  - `o_valid`=0, `o_pos`=8'h00, `o_value`=8'h00, `o_idle`=0.
  - Shadow buffer is all 8'h00, all 16 dirty bits are set, the state is IDLE, and the index is 0.
  - Consequence: a full-frame burst starts immediately after reset.
- Shadow write:
  - `i_wr_en` writes `i_wr_data` to `shadow[i_wr_addr]` and sets `dirty[i_wr_addr]`.
  - Writes are accepted in every state, with no back-pressure.
- `i_refresh` sets all dirty bits. If it coincides with a write, the write still lands.
- Set-wins rule: if a byte's dirty bit is cleared by SEND in the same cycle it is set by a write or refresh, the bit stays set.
- States:
  - IDLE: if `|dirty`, go to CMD. Otherwise hold, with `o_idle`=1.
  - CMD: when `i_busy`=0, drive `o_valid`=1, `o_pos`=8'h00, `o_value`=`CMD_BASE|i_brightness`, clear the pause counter, and go to PAUSE. Otherwise wait.
  - PAUSE: count `PAUSE_CYCLES`, then clear the index to 0 and go to SCAN.
  - SCAN: if `dirty[idx]`, go to SEND. Otherwise, if idx=15 go to IDLE, else increment idx.
  - SEND: when `i_busy`=0, drive `o_valid`=1, `o_pos`=`ADDR_BASE+idx`, `o_value`=`shadow[idx]`, clear `dirty[idx]`, and go to GUARD.
  - GUARD: hold `o_valid`=0 for at least 2 cycles, then wait for `i_busy`=0. Then, if idx=15 go to IDLE, else increment idx and go to SCAN.
  - CMD also passes through GUARD before PAUSE.
- Address arithmetic is 8-bit and unsigned. The 4-bit idx is zero-extended, so there is no wrap for the default `ADDR_BASE`.
- Bytes dirtied behind the scan index during a burst are handled by the next burst, started from IDLE.
- `RST` asserted mid-burst:
  - On the next edge, `o_valid`=0, the state is IDLE, and all bits are dirty.
  - The shadow is zeroed.
  - Any transfer already accepted by the driver is not tracked.

## Timing
- `o_valid` is only ever a single-cycle pulse. It is never high on two consecutive cycles. It is never asserted in a cycle where `i_busy`=1.
- `o_pos` and `o_value` are registered, valid in the `o_valid` cycle, and held until the next pulse.
- Latency from IDLE with dirty data to the command pulse is 2 cycles when `i_busy`=0.
- The gap from the command pulse to the first data pulse is at least `PAUSE_CYCLES` + 3 cycles.
- Each clean byte skipped costs 1 SCAN cycle. Each sent byte costs SEND + GUARD (at least 3 cycles) plus the driver busy time.
- A write presented in the same cycle as a SEND of that index is not reflected in that transfer. It is re-sent in the next burst.

## Test plan
- Reset, driver model busy for 10 cycles per transfer, `i_brightness`=3'd1, `PAUSE_CYCLES`=4:
  - Required: exactly 17 pulses. Pulse 1 is pos 00 / value 89. Then pos C0..CF with value 00, in order. Then `o_idle`=1.
- From idle, write addr 5 = 8'hA5:
  - Required: pos 00 / value 89, then a single pulse pos C5 / value A5, then idle. No other addresses are written.
- Write addr 3 = 8'h3C in the SEND cycle of idx 3 during a burst:
  - Required: the current burst sends the old value. A second burst then sends pos C3 / value 3C.
- Hold `i_busy`=1 for 50 cycles while in CMD:
  - Required: no `o_valid` while busy high. Exactly one pulse on the first cycle after busy falls.
- `i_refresh` pulse in idle after a full burst:
  - Required: all 16 addresses C0..CF are rewritten with current shadow contents.
- Assert `RST` for 1 cycle while idx=7 is in GUARD:
  - Required: `o_valid`=0 and all outputs at reset values after the edge. A full 17-pulse burst follows.
